// File: rtl/barrett_pkg.sv
// Shared constants and state encoding for the Barrett constant generator.
package barrett_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int U_W        = 2 * DATA_W_DEF;

  // Quotient bits retired per enabled CALC cycle.
  localparam int STEPS_R2   = 1;
  localparam int STEPS_R4   = 2;
  localparam int ITER_R2    = U_W / STEPS_R2;
  localparam int ITER_R4    = U_W / STEPS_R4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } barrett_cg_state_t;

endpackage

// File: rtl/barrett_div_step.sv
// One restoring-division step: doubles the partial remainder and conditionally
// subtracts the modulus, yielding the next remainder and one quotient bit.
module barrett_div_step #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W:0]   remIn,
  input  logic [DATA_W-1:0] modIn,
  output logic [DATA_W:0]   remOut,
  output logic              qBit
);

  logic [DATA_W:0] dbl;
  logic [DATA_W:0] modExt;

  // remIn < M, so doubling never overflows DATA_W+1 bits.
  assign dbl    = remIn << 1;
  assign modExt = {1'b0, modIn};
  assign qBit   = (dbl >= modExt);
  assign remOut = qBit ? (dbl - modExt) : dbl;

endmodule

// File: rtl/barrett_const_gen_64b.sv
// Sequential generator of U = floor(2^(2*DATA_W) / M) by restoring division.
// Define BARRETT_CONST_RADIX4_EN to retire two quotient bits per cycle.
module barrett_const_gen_64b
  import barrett_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iEn,
  input  logic                  iClr,
  input  logic                  iStart,
  input  logic [DATA_W-1:0]     iMod,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oValid,
  output logic                  oErr,
  output logic [2*DATA_W-1:0]   oU,
  output logic [DATA_W-1:0]     oMod
);

  localparam int UW = 2 * DATA_W;
`ifdef BARRETT_CONST_RADIX4_EN
  localparam int ITERS = UW / STEPS_R4;
`else
  localparam int ITERS = UW / STEPS_R2;
`endif
  localparam int CNT_W = $clog2(ITERS + 1);

  barrett_cg_state_t state;
  logic [DATA_W-1:0] modReg;
  logic [DATA_W:0]   rem;
  logic [UW-1:0]     quo;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   remNext;
  logic [UW-1:0]     quoNext;

  logic [DATA_W:0]   remA;
  logic              qA;

  barrett_div_step #(.DATA_W(DATA_W)) uStepA (
    .remIn (rem),
    .modIn (modReg),
    .remOut(remA),
    .qBit  (qA)
  );

`ifdef BARRETT_CONST_RADIX4_EN
  logic [DATA_W:0] remB;
  logic            qB;

  // Second step chained combinationally; qA is the more significant bit.
  barrett_div_step #(.DATA_W(DATA_W)) uStepB (
    .remIn (remA),
    .modIn (modReg),
    .remOut(remB),
    .qBit  (qB)
  );

  assign remNext = remB;
  assign quoNext = {quo[UW-3:0], qA, qB};
`else
  assign remNext = remA;
  assign quoNext = {quo[UW-2:0], qA};
`endif

  assign oMod = modReg;

  always_ff @(posedge iClk) begin
    oDone <= 1'b0;
    if (!iRstN || iClr) begin
      state  <= IDLE;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
      oU     <= '0;
      modReg <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
    end else if (iEn) begin
      case (state)
        IDLE: begin
          if (iStart) begin
            modReg <= iMod;
            oValid <= 1'b0;
            if (iMod < DATA_W'(2)) begin
              // Degenerate modulus: saturate the constant and flag it.
              oErr  <= 1'b1;
              quo   <= '1;
              state <= DONE;
            end else begin
              oErr  <= 1'b0;
              rem   <= (DATA_W+1)'(1);
              quo   <= '0;
              cnt   <= '0;
              oBusy <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= remNext;
          quo <= quoNext;
          if (cnt == CNT_W'(ITERS - 1)) begin
            oBusy <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          oDone  <= 1'b1;
          oValid <= 1'b1;
          oU     <= quo;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_const_gen_64b.sv
// Randomized and directed bench for barrett_const_gen_64b against a wide-division model.
module tb_barrett_const_gen_64b;

`ifdef BARRETT_CONST_RADIX4_EN
  localparam int LAT = 65;
`else
  localparam int LAT = 129;
`endif

  logic         iClk = 1'b0;
  logic         iRstN, iEn, iClr, iStart;
  logic [63:0]  iMod;
  logic         oBusy, oDone, oValid, oErr;
  logic [127:0] oU;
  logic [63:0]  oMod;

  int nChecks = 0;
  int nPass   = 0;

  barrett_const_gen_64b dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .iStart(iStart),
    .iMod  (iMod),
    .oBusy (oBusy),
    .oDone (oDone),
    .oValid(oValid),
    .oErr  (oErr),
    .oU    (oU),
    .oMod  (oMod)
  );

  always #5 iClk = ~iClk;

  function automatic logic [127:0] refU(input logic [63:0] m);
    logic [128:0] num;
    if (m < 64'd2) return '1;
    num = 129'd1 << 128;
    return 128'(num / {65'd0, m});
  endfunction

  task automatic startOp(input logic [63:0] m);
    @(negedge iClk);
    iMod   = m;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iMod   = {$urandom, $urandom};
  endtask

  task automatic waitDone(input int bound, output int lat);
    lat = 0;
    while (oDone !== 1'b1 && lat < bound) begin
      @(posedge iClk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0; iStart = 1'b0; iMod = '0;
    repeat (3) @(posedge iClk);
    #1;
    nChecks++;
    if ({oBusy, oDone, oValid, oErr, oU, oMod} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b err=%b u=%h mod=%h, want all zero",
               oBusy, oDone, oValid, oErr, oU, oMod);
    else nPass++;
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  task automatic checkOp(input string name, input logic [63:0] m);
    int lat;
    logic [127:0] expU;
    int expLat;
    expU   = refU(m);
    expLat = (m < 64'd2) ? 1 : LAT;
    startOp(m);
    nChecks++;
    if (oBusy !== (m >= 64'd2) || oValid !== 1'b0)
      $display("FAIL %s_start: busy=%b valid=%b, want busy=%b valid=0", name, oBusy, oValid, m >= 64'd2);
    else nPass++;
    waitDone(400, lat);
    nChecks++;
    if (lat != expLat) $display("FAIL %s_latency: got %0d, want %0d", name, lat, expLat);
    else nPass++;
    nChecks++;
    if (oU !== expU || oErr !== (m < 64'd2) || oValid !== 1'b1 || oMod !== m)
      $display("FAIL %s_result: u=%h err=%b valid=%b mod=%h, want u=%h err=%b valid=1 mod=%h",
               name, oU, oErr, oValid, oMod, expU, m < 64'd2, m);
    else nPass++;
    @(posedge iClk);
    #1;
    nChecks++;
    if (oDone !== 1'b0 || oValid !== 1'b1 || oU !== expU || oBusy !== 1'b0)
      $display("FAIL %s_pulse: done=%b valid=%b busy=%b u=%h, want done=0 valid=1 busy=0 u=%h",
               name, oDone, oValid, oBusy, oU, expU);
    else nPass++;
  endtask

  task automatic test_directed;
    checkOp("m_allones", 64'hFFFF_FFFF_FFFF_FFFF);
    checkOp("m_3", 64'd3);
    checkOp("m_2", 64'd2);
    checkOp("m_2pow63", 64'h8000_0000_0000_0000);
    checkOp("m_7", 64'd7);
  endtask

  task automatic test_small;
    checkOp("m_1", 64'd1);
    checkOp("m_0", 64'd0);
  endtask

  task automatic test_random;
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m = {$urandom, $urandom};
      if (i < 3) m = m >> (20 * (i + 1));
      if (m < 64'd2) m = 64'd5;
      checkOp("m_random", m);
    end
  endtask

  task automatic test_clear;
    int lat;
    startOp({$urandom, $urandom} | 64'h1_0000);
    repeat (50) @(posedge iClk);
    @(negedge iClk);
    iClr = 1'b1;
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    nChecks++;
    if ({oBusy, oDone, oValid, oErr, oU, oMod} !== '0)
      $display("FAIL clear_outputs: busy=%b done=%b valid=%b err=%b u=%h mod=%h, want all zero",
               oBusy, oDone, oValid, oErr, oU, oMod);
    else nPass++;
    waitDone(200, lat);
    nChecks++;
    if (lat != 200) $display("FAIL clear_no_done: done seen %0d cycles after clear, want none", lat);
    else nPass++;
    checkOp("clear_then_m7", 64'd7);
    nChecks++;
    if (oU !== 128'h2492_4924_9249_2492_4924_9249_2492_4924)
      $display("FAIL clear_m7_const: got %h, want 24924924924924924924924924924924", oU);
    else nPass++;
  endtask

  task automatic test_stall;
    logic [63:0] m;
    int cyc;
    bit found;
    m = {$urandom, $urandom} | 64'h8000;
    startOp(m);
    cyc = 0;
    found = 0;
    while (!found && cyc < 400) begin
      @(negedge iClk);
      iEn    = (cyc >= 20 && cyc < 30) ? 1'b0 : 1'b1;
      iStart = (cyc == 5 || cyc == 40) ? 1'b1 : 1'b0;
      iMod   = {$urandom, $urandom};
      @(posedge iClk);
      #1;
      cyc++;
      if (oDone === 1'b1) found = 1;
    end
    iEn = 1'b1; iStart = 1'b0;
    nChecks++;
    if (cyc != LAT + 10) $display("FAIL stall_latency: got %0d, want %0d", cyc, LAT + 10);
    else nPass++;
    nChecks++;
    if (oU !== refU(m) || oMod !== m)
      $display("FAIL stall_result: u=%h mod=%h, want u=%h mod=%h", oU, oMod, refU(m), m);
    else nPass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] m1, m2;
    m1 = {$urandom, $urandom} | 64'h3;
    m2 = {$urandom, 32'h0} | 64'h11;
    startOp(m1);
    waitDone(400, lat);
    nChecks++;
    if (oU !== refU(m1)) $display("FAIL b2b_first: got %h, want %h", oU, refU(m1));
    else nPass++;
    startOp(m2);
    nChecks++;
    if (oValid !== 1'b0 || oBusy !== 1'b1)
      $display("FAIL b2b_restart: valid=%b busy=%b, want valid=0 busy=1", oValid, oBusy);
    else nPass++;
    waitDone(400, lat);
    nChecks++;
    if (lat != LAT || oU !== refU(m2))
      $display("FAIL b2b_second: lat=%0d u=%h, want lat=%0d u=%h", lat, oU, LAT, refU(m2));
    else nPass++;
  endtask

  task automatic test_reset_mid;
    int lat;
    startOp(64'd12345);
    repeat (30) @(posedge iClk);
    @(negedge iClk);
    iRstN = 1'b0;
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    nChecks++;
    if ({oBusy, oDone, oValid, oErr, oU, oMod} !== '0)
      $display("FAIL reset_mid_outputs: busy=%b done=%b valid=%b err=%b u=%h mod=%h, want all zero",
               oBusy, oDone, oValid, oErr, oU, oMod);
    else nPass++;
    waitDone(150, lat);
    nChecks++;
    if (lat != 150) $display("FAIL reset_mid_no_done: done seen after %0d cycles, want none", lat);
    else nPass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_small;
    test_random;
    test_clear;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
